// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_pkg
// Brief    : State encoding and shared constants for the FPU register sequencer
// Revision : 1.0
// ============================================================================
package fpu_seq_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WRITE   = 3'd4
    } seq_state_e;

    // Counter width able to hold TIMEOUT (8 bits for the default of 255).
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_reg_sequencer_if
// Brief    : Request, register-file, FPU and response signals of the sequencer
// Revision : 1.0
// ============================================================================
interface fpu_reg_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rs3;
    logic        req_wb;

    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [4:0]  reg3;
    logic        reg_read;
    logic        reg_write;
    logic [31:0] write_data;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] operand3;

    logic        fpu_valid;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_c;
    logic        fpu_done;
    logic [31:0] fpu_result;

    logic        resp_done;
    logic        resp_err;

    modport master (
        input  req_valid, req_rd, req_rs1, req_rs2, req_rs3, req_wb,
        input  operand1, operand2, operand3, fpu_done, fpu_result,
        output req_ready, reg1, reg2, reg3, reg_read, reg_write, write_data,
        output fpu_valid, fpu_a, fpu_b, fpu_c, resp_done, resp_err
    );

    modport slave (
        output req_valid, req_rd, req_rs1, req_rs2, req_rs3, req_wb,
        output operand1, operand2, operand3, fpu_done, fpu_result,
        input  req_ready, reg1, reg2, reg3, reg_read, reg_write, write_data,
        input  fpu_valid, fpu_a, fpu_b, fpu_c, resp_done, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/fpu_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_timer
// Brief    : EXEC wait counter; expired_o flags the cycle whose count reaches TIMEOUT
// Revision : 1.0
// ============================================================================
module fpu_seq_timer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/fpu_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_reg_sequencer
// Brief    : Reads operands, waits for the FPU and writes back one instruction at a time
// Revision : 1.0
// ============================================================================
module fpu_reg_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    fpu_reg_sequencer_if.master bus
);

    seq_state_e  state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_q, wb_d;
    logic        req_ready_q, reg_read_q, reg_write_q, fpu_valid_q;
    logic        resp_done_q, resp_done_d, resp_err_q, resp_err_d;
    logic [4:0]  reg1_q, reg1_d, reg2_q, reg2_d, reg3_q, reg3_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d, fpu_c_q, fpu_c_d;
    logic        exec_expired;

    fpu_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (state_q != ST_EXEC),
        .enable_i  (state_q == ST_EXEC),
        .expired_o (exec_expired)
    );

    // Output values are computed for the state being entered, so every port is a flop.
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wb_d         = wb_q;
        reg1_d       = '0;
        reg2_d       = '0;
        reg3_d       = '0;
        write_data_d = '0;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_c_d      = fpu_c_q;
        resp_done_d  = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = ST_READ;
                    rd_d    = bus.req_rd;
                    wb_d    = bus.req_wb;
                    reg1_d  = bus.req_rs1;
                    reg2_d  = bus.req_rs2;
                    reg3_d  = bus.req_rs3;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                fpu_a_d = bus.operand1;
                fpu_b_d = bus.operand2;
                fpu_c_d = bus.operand3;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.fpu_done) begin
                    if (wb_q) begin
                        state_d      = ST_WRITE;
                        reg1_d       = rd_q;
                        write_data_d = bus.fpu_result;
                    end else begin
                        state_d     = ST_IDLE;
                        resp_done_d = 1'b1;
                    end
                end else if (exec_expired) begin
                    state_d    = ST_IDLE;
                    resp_err_d = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d     = ST_IDLE;
                resp_done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rd_q         <= '0;
            wb_q         <= 1'b0;
            req_ready_q  <= 1'b0;
            reg_read_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            fpu_valid_q  <= 1'b0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            reg3_q       <= '0;
            write_data_q <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_c_q      <= '0;
            resp_done_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wb_q         <= wb_d;
            req_ready_q  <= (state_d == ST_IDLE);
            reg_read_q   <= (state_d == ST_READ);
            reg_write_q  <= (state_d == ST_WRITE);
            fpu_valid_q  <= (state_d == ST_EXEC);
            reg1_q       <= reg1_d;
            reg2_q       <= reg2_d;
            reg3_q       <= reg3_d;
            write_data_q <= write_data_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_c_q      <= fpu_c_d;
            resp_done_q  <= resp_done_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.reg_read   = reg_read_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.reg1       = reg1_q;
    assign bus.reg2       = reg2_q;
    assign bus.reg3       = reg3_q;
    assign bus.write_data = write_data_q;
    assign bus.fpu_valid  = fpu_valid_q;
    assign bus.fpu_a      = fpu_a_q;
    assign bus.fpu_b      = fpu_b_q;
    assign bus.fpu_c      = fpu_c_q;
    assign bus.resp_done  = resp_done_q;
    assign bus.resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_reg_sequencer
// Brief    : Scoreboard bench with register-file and FPU models around the sequencer
// Revision : 1.0
// ============================================================================
module tb_fpu_reg_sequencer;

    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fpu_reg_sequencer_if bus();

    fpu_reg_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    wr_t        exp_wr[$];
    logic [1:0] exp_resp[$];

    // Register file: read data appears the cycle after reg_read, writes land at the edge.
    logic [31:0] rf [32];
    logic [31:0] op1 = '0, op2 = '0, op3 = '0;
    logic        s_rd, s_wr;
    logic [4:0]  s_r1, s_r2, s_r3;
    logic [31:0] s_wd;
    assign bus.operand1 = op1;
    assign bus.operand2 = op2;
    assign bus.operand3 = op3;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {4{8'(i)}};
        rf[1] = 32'h3F80_0000;
        rf[2] = 32'h4000_0000;
        rf[4] = 32'h0000_0000;
        forever begin
            @(posedge clk);
            s_rd = bus.reg_read;  s_wr = bus.reg_write;
            s_r1 = bus.reg1; s_r2 = bus.reg2; s_r3 = bus.reg3; s_wd = bus.write_data;
            #1;
            if (s_rd) begin
                op1 = rf[s_r1]; op2 = rf[s_r2]; op3 = rf[s_r3];
            end
            if (s_wr) rf[s_r1] = s_wd;
        end
    end

    // FPU model: done pulses in the fpu_lat-th EXEC cycle; fpu_lat=0 never answers.
    logic        model_done = 1'b0, force_done = 1'b0, fpu_use_sum = 1'b0;
    int          fpu_lat = 0, fpu_cnt = 0;
    logic [31:0] fpu_res_value = '0;
    assign bus.fpu_done   = model_done | force_done;
    assign bus.fpu_result = fpu_use_sum ? (bus.fpu_a + bus.fpu_b + bus.fpu_c) : fpu_res_value;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.fpu_valid && !model_done) begin
                fpu_cnt++;
                model_done = (fpu_cnt == fpu_lat);
            end else begin
                fpu_cnt    = 0;
                model_done = 1'b0;
            end
        end
    end

    // Monitor: records what the DUT presents each cycle.
    int          cyc = 0, n_reads = 0, n_writes = 0, n_resp = 0, n_exec = 0;
    int          read_cyc = 0, fdone_cyc = 0, rw_conflicts = 0;
    logic [4:0]  rd_r1, rd_r2, rd_r3;
    logic [31:0] exec_a, exec_b;
    wr_t         wr_log [64];
    int          wr_cyc [64];
    logic [1:0]  resp_code [64];
    int          resp_cyc [64];
    logic        resp_rdy [64];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.reg_read && bus.reg_write) rw_conflicts++;
            if (bus.reg_read) begin
                n_reads++; read_cyc = cyc;
                rd_r1 = bus.reg1; rd_r2 = bus.reg2; rd_r3 = bus.reg3;
            end
            if (bus.reg_write && n_writes < 64) begin
                wr_log[n_writes] = {bus.reg1, bus.write_data};
                wr_cyc[n_writes] = cyc;
                n_writes++;
            end
            if ((bus.resp_done || bus.resp_err) && n_resp < 64) begin
                resp_code[n_resp] = {bus.resp_err, bus.resp_done};
                resp_cyc[n_resp]  = cyc;
                resp_rdy[n_resp]  = bus.req_ready;
                n_resp++;
            end
            if (bus.fpu_valid) begin
                n_exec++; exec_a = bus.fpu_a; exec_b = bus.fpu_b;
                if (bus.fpu_done) fdone_cyc = cyc;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(bus.reg_read && bus.reg_write))
        else $error("FAIL rw_exclusive: reg_read and reg_write both 1");

    task automatic send_req(input logic [4:0] rd, rs1, rs2, rs3, input logic wb);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_rd = rd; bus.req_wb = wb;
        bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_rs3 = rs3;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, output bit ok);
        int n = 0;
        while (n_resp < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n_resp >= target);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.reg_read, bus.reg_write, bus.fpu_valid, bus.resp_done, bus.resp_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready/rd/wr/valid/done/err=%b, required 000000",
                     {bus.req_ready, bus.reg_read, bus.reg_write, bus.fpu_valid, bus.resp_done, bus.resp_err});
        end
        total++;
        if ({bus.reg1, bus.reg2, bus.reg3, bus.write_data, bus.fpu_a, bus.fpu_b, bus.fpu_c} !== '0) begin
            bad++;
            $display("FAIL reset_data: regs/data/operands=%h, required 0",
                     {bus.reg1, bus.reg2, bus.reg3, bus.write_data, bus.fpu_a, bus.fpu_b, bus.fpu_c});
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b after release, required 1", bus.req_ready);
        end
    endtask

    task automatic test_writeback();
        int r0 = n_reads, w0 = n_writes, s0 = n_resp;
        bit ok;
        wr_t want;
        logic [1:0] want_r;
        fpu_use_sum = 1'b0; fpu_lat = 3; fpu_res_value = 32'h4040_0000;
        exp_wr.push_back({5'd3, 32'h4040_0000});
        exp_resp.push_back(2'b01);
        send_req(5'd3, 5'd1, 5'd2, 5'd4, 1'b1);
        wait_resp(s0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wb_resp_wait: responses=%0d, required %0d", n_resp - s0, 1); end
        total++;
        if (n_reads - r0 != 1 || {rd_r1, rd_r2, rd_r3} !== {5'd1, 5'd2, 5'd4}) begin
            bad++;
            $display("FAIL wb_read: reads=%0d regs=%0d/%0d/%0d, required 1 read of 1/2/4", n_reads - r0, rd_r1, rd_r2, rd_r3);
        end
        total++;
        if (exec_a !== 32'h3F80_0000 || exec_b !== 32'h4000_0000) begin
            bad++;
            $display("FAIL wb_operands: fpu_a=%h fpu_b=%h, required 3f800000 40000000", exec_a, exec_b);
        end
        want = exp_wr.pop_front();
        total++;
        if (n_writes - w0 != 1 || wr_log[w0] !== want) begin
            bad++;
            $display("FAIL wb_write: writes=%0d got %h, required 1 write of %h", n_writes - w0, wr_log[w0], want);
        end
        total++;
        if (wr_cyc[w0] != read_cyc + 5) begin
            bad++;
            $display("FAIL wb_latency: write %0d cycles after read, required 5", wr_cyc[w0] - read_cyc);
        end
        want_r = exp_resp.pop_front();
        total++;
        if (resp_code[s0] !== want_r || resp_cyc[s0] != wr_cyc[w0] + 1) begin
            bad++;
            $display("FAIL wb_done: code=%b at +%0d after write, required %b at +1", resp_code[s0], resp_cyc[s0] - wr_cyc[w0], want_r);
        end
    endtask

    task automatic test_no_writeback();
        int w0 = n_writes, s0 = n_resp;
        bit ok;
        logic [1:0] want_r;
        fpu_use_sum = 1'b0; fpu_lat = 3; fpu_res_value = 32'h4040_0000;
        exp_resp.push_back(2'b01);
        send_req(5'd3, 5'd1, 5'd2, 5'd4, 1'b0);
        wait_resp(s0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nowb_resp_wait: responses=%0d, required %0d", n_resp - s0, 1); end
        total++;
        if (n_writes != w0) begin bad++; $display("FAIL nowb_write: writes=%0d, required 0", n_writes - w0); end
        total++;
        if (fdone_cyc != read_cyc + 4) begin
            bad++;
            $display("FAIL nowb_exec: fpu_done %0d cycles after read, required 4", fdone_cyc - read_cyc);
        end
        want_r = exp_resp.pop_front();
        total++;
        if (resp_code[s0] !== want_r || resp_cyc[s0] != fdone_cyc + 1) begin
            bad++;
            $display("FAIL nowb_done: code=%b at +%0d after fpu_done, required %b at +1", resp_code[s0], resp_cyc[s0] - fdone_cyc, want_r);
        end
    endtask

    task automatic test_timeout();
        int w0 = n_writes, s0 = n_resp, e0 = n_exec;
        bit ok;
        logic [1:0] want_r;
        fpu_lat = 0;
        exp_resp.push_back(2'b10);
        send_req(5'd7, 5'd1, 5'd2, 5'd3, 1'b1);
        wait_resp(s0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_resp_wait: responses=%0d, required %0d", n_resp - s0, 1); end
        total++;
        if (n_exec - e0 != TB_TIMEOUT) begin
            bad++;
            $display("FAIL to_exec_cycles: got %0d EXEC cycles, required %0d", n_exec - e0, TB_TIMEOUT);
        end
        want_r = exp_resp.pop_front();
        total++;
        if (resp_code[s0] !== want_r || resp_cyc[s0] != read_cyc + 10) begin
            bad++;
            $display("FAIL to_err: code=%b at +%0d after read, required %b at +10", resp_code[s0], resp_cyc[s0] - read_cyc, want_r);
        end
        total++;
        if (resp_rdy[s0] !== 1'b1) begin bad++; $display("FAIL to_ready: req_ready=%b with resp_err, required 1", resp_rdy[s0]); end
        total++;
        if (n_writes != w0) begin bad++; $display("FAIL to_write: writes=%0d, required 0", n_writes - w0); end
    endtask

    task automatic test_reset_in_exec();
        int w0 = n_writes, s0 = n_resp, e0 = n_exec, n = 0;
        fpu_lat = 0;
        send_req(5'd10, 5'd1, 5'd2, 5'd3, 1'b1);
        while (n_exec == e0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n_exec == e0) begin bad++; $display("FAIL rst_exec_wait: EXEC cycles=%0d, required >0", n_exec - e0); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.reg_read, bus.reg_write, bus.fpu_valid, bus.resp_done, bus.resp_err,
             bus.reg1, bus.reg2, bus.reg3, bus.write_data, bus.fpu_a, bus.fpu_b, bus.fpu_c} !== '0) begin
            bad++;
            $display("FAIL rst_exec_outputs: ctrl=%b data=%h, required all 0",
                     {bus.req_ready, bus.reg_read, bus.reg_write, bus.fpu_valid, bus.resp_done, bus.resp_err},
                     {bus.reg1, bus.reg2, bus.reg3, bus.write_data, bus.fpu_a, bus.fpu_b, bus.fpu_c});
        end
        reset_n    = 1'b1;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        total++;
        if (bus.req_ready !== 1'b1 || bus.fpu_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_exec_idle: req_ready=%b fpu_valid=%b, required 1 0", bus.req_ready, bus.fpu_valid);
        end
        repeat (5) @(negedge clk);
        total++;
        if (n_writes != w0 || n_resp != s0) begin
            bad++;
            $display("FAIL rst_exec_quiet: writes=%0d responses=%0d, required 0 0", n_writes - w0, n_resp - s0);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = n_writes, s0 = n_resp;
        bit ok;
        wr_t want;
        logic [1:0] want_r;
        logic [31:0] exp1, exp2;
        fpu_use_sum = 1'b1; fpu_lat = 2;
        exp1 = rf[6] + rf[7] + rf[8];
        exp2 = exp1 + rf[6] + rf[0];
        exp_wr.push_back({5'd5, exp1});
        exp_wr.push_back({5'd9, exp2});
        exp_resp.push_back(2'b01);
        exp_resp.push_back(2'b01);
        send_req(5'd5, 5'd6, 5'd7, 5'd8, 1'b1);
        send_req(5'd9, 5'd5, 5'd6, 5'd0, 1'b1);
        wait_resp(s0 + 2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_resp_wait: responses=%0d, required %0d", n_resp - s0, 2); end
        for (int k = 0; k < 2; k++) begin
            want   = exp_wr.pop_front();
            want_r = exp_resp.pop_front();
            total++;
            if (n_writes - w0 <= k || wr_log[w0 + k] !== want || resp_code[s0 + k] !== want_r) begin
                bad++;
                $display("FAIL b2b_op%0d: write %h resp %b, required write %h resp %b",
                         k, wr_log[w0 + k], resp_code[s0 + k], want, want_r);
            end
        end
        total++;
        if (exec_a !== exp1) begin bad++; $display("FAIL b2b_forward: fpu_a=%h, required %h", exec_a, exp1); end
        total++;
        if (read_cyc != wr_cyc[w0] + 2) begin
            bad++;
            $display("FAIL b2b_order: second read %0d cycles after first write, required 2", read_cyc - wr_cyc[w0]);
        end
        total++;
        if (resp_cyc[s0 + 1] != wr_cyc[w0 + 1] + 1) begin
            bad++;
            $display("FAIL b2b_done: done %0d cycles after write, required 1", resp_cyc[s0 + 1] - wr_cyc[w0 + 1]);
        end
    endtask

    task automatic test_rw_exclusive();
        total++;
        if (rw_conflicts != 0) begin
            bad++;
            $display("FAIL rw_exclusive: %0d cycles with reg_read and reg_write, required 0", rw_conflicts);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rd    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rs3   = '0;
        bus.req_wb    = 1'b0;
        test_reset();
        test_writeback();
        test_no_writeback();
        test_timeout();
        test_reset_in_exec();
        test_back_to_back();
        test_rw_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
